// File: rtl/databus_row_capture.sv
// Row capture: assembles four databus words into one row, NROWS rows per frame.
// Latency: row_valid rises one cycle after the write that fills the last empty slot.
// Backpressure: bus_ready drops while a row is presented; it returns the cycle after row_ack.
module databus_row_capture #(
   parameter int DW    = 4,
   parameter int NROWS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   bus_in,
   input  logic            bus_valid,
   input  logic [1:0]      dest_sel,
   output logic            bus_ready,
   output logic [4*DW-1:0] row_out,
   output logic            row_valid,
   input  logic            row_ack,
   output logic [1:0]      row_idx,
   output logic [3:0]      slot_mask,
   output logic            frame_done
);

   typedef enum logic {FILL, FULL} state_t;

   state_t     state;
   logic [3:0] mask_next;
   logic [1:0] last_idx;

   assign last_idx = 2'(NROWS - 1);

   // Slot mask as it would look after writing dest_sel this cycle
   always_comb mask_next = slot_mask | (4'b0001 << dest_sel);

   // Fill/present FSM; every output is a register so nothing combinational reaches a port
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         row_out    <= '0;
         slot_mask  <= '0;
         row_idx    <= '0;
         row_valid  <= 1'b0;
         bus_ready  <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            FILL: begin
               // A rewritten slot just takes the newer word; the mask bit is already set
               if (bus_valid) begin
                  row_out[int'(dest_sel)*DW +: DW] <= bus_in;
                  slot_mask <= mask_next;
                  if (mask_next == 4'b1111) begin
                     state     <= FULL;
                     row_valid <= 1'b1;
                     bus_ready <= 1'b0;
                  end
               end
            end
            FULL: begin
               // Slot contents survive the acknowledge; only new writes replace them
               if (row_ack) begin
                  state     <= FILL;
                  row_valid <= 1'b0;
                  bus_ready <= 1'b1;
                  slot_mask <= '0;
                  if (row_idx == last_idx) begin
                     row_idx    <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     row_idx <= row_idx + 2'd1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_databus_row_capture.sv
// Bench for databus_row_capture: scoreboarded rows plus directed control checks.
// Latency: expects row_valid on the cycle after the completing write.
// Backpressure: exercises bus_valid held high while a row is presented.
module tb_databus_row_capture;

   localparam int DW    = 4;
   localparam int NROWS = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   bus_in = '0;
   logic            bus_valid = 1'b0;
   logic [1:0]      dest_sel = '0;
   logic            bus_ready;
   logic [4*DW-1:0] row_out;
   logic            row_valid;
   logic            row_ack = 1'b0;
   logic [1:0]      row_idx;
   logic [3:0]      slot_mask;
   logic            frame_done;

   typedef struct {
      logic [4*DW-1:0] row;
      logic [1:0]      idx;
   } exp_row_t;

   exp_row_t   sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         fd_count = 0;
   logic       prev_valid = 1'b0;

   // reference model state
   logic [DW-1:0] m_slot[4];
   logic [3:0]    m_mask;
   logic [1:0]    m_idx;
   logic          m_full;
   logic          m_fd;

   databus_row_capture #(.DW(DW), .NROWS(NROWS)) dut (
      .clk(clk), .rst(rst), .bus_in(bus_in), .bus_valid(bus_valid),
      .dest_sel(dest_sel), .bus_ready(bus_ready), .row_out(row_out),
      .row_valid(row_valid), .row_ack(row_ack), .row_idx(row_idx),
      .slot_mask(slot_mask), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*DW-1:0] m_row();
      return {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      m_mask = '0;
      m_idx  = '0;
      m_full = 1'b0;
      m_fd   = 1'b0;
   endtask

   // scoreboard: compare each newly presented row against the oldest expectation
   always @(negedge clk) begin
      if (row_valid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_row", 32'(row_out), 32'hFFFF_FFFF);
         end else begin
            exp_row_t e;
            e = sb_q.pop_front();
            chk("sb_row_out", 32'(row_out), 32'(e.row));
            chk("sb_row_idx", 32'(row_idx), 32'(e.idx));
         end
      end
      prev_valid = row_valid;
      if (frame_done) fd_count++;
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

   task automatic write(input logic [1:0] slot, input logic [DW-1:0] val);
      bus_valid = 1'b1;
      dest_sel  = slot;
      bus_in    = val;
      @(posedge clk);
      #1;
      bus_valid = 1'b0;
      m_fd = 1'b0;
      if (!m_full) begin
         m_slot[slot] = val;
         m_mask[slot] = 1'b1;
         if (m_mask == 4'b1111) begin
            m_full = 1'b1;
            sb_q.push_back('{row: m_row(), idx: m_idx});
         end
      end
   endtask

   task automatic ack();
      row_ack = 1'b1;
      @(posedge clk);
      #1;
      row_ack = 1'b0;
      m_fd = 1'b0;
      if (m_full) begin
         m_full = 1'b0;
         m_mask = '0;
         if (m_idx == 2'(NROWS - 1)) begin
            m_idx = '0;
            m_fd  = 1'b1;
         end else begin
            m_idx = m_idx + 2'd1;
         end
      end
   endtask

   task automatic chk_ctrl(input string tag);
      chk({tag, "_ready"}, 32'(bus_ready), 32'(!m_full));
      chk({tag, "_valid"}, 32'(row_valid), 32'(m_full));
      chk({tag, "_mask"},  32'(slot_mask), 32'(m_mask));
      chk({tag, "_idx"},   32'(row_idx),   32'(m_idx));
      chk({tag, "_fd"},    32'(frame_done), 32'(m_fd));
   endtask

   initial begin
      logic [4*DW-1:0] held;
      int fd_base;

      m_reset();
      do_reset(2);
      chk_ctrl("reset");
      chk("reset_row_out", 32'(row_out), 32'h0);

      // in-order fill
      write(2'd0, 4'hA);
      write(2'd1, 4'hB);
      write(2'd2, 4'hC);
      chk_ctrl("inorder_partial");
      write(2'd3, 4'hD);
      chk("inorder_row_out", 32'(row_out), 32'hDCBA);
      chk("inorder_valid", 32'(row_valid), 32'h1);
      chk("inorder_ready", 32'(bus_ready), 32'h0);
      chk("inorder_idx", 32'(row_idx), 32'h0);
      ack();
      chk_ctrl("inorder_ack");
      chk("ack_keeps_row", 32'(row_out), 32'hDCBA);

      // out-of-order fill with an overwrite
      write(2'd2, 4'h1);
      chk("ooo_nv1", 32'(row_valid), 32'h0);
      write(2'd2, 4'h7);
      chk("ooo_nv2", 32'(row_valid), 32'h0);
      chk("ooo_mask_rewrite", 32'(slot_mask), 32'h4);
      write(2'd0, 4'h3);
      chk("ooo_nv3", 32'(row_valid), 32'h0);
      write(2'd3, 4'hF);
      chk("ooo_nv4", 32'(row_valid), 32'h0);
      write(2'd1, 4'h5);
      chk("ooo_row_out", 32'(row_out), 32'hF753);
      chk_ctrl("ooo_full");
      ack();
      chk_ctrl("ooo_ack");

      // backpressure: bus_valid held while a row is presented
      for (int i = 0; i < 4; i++) write(2'(i), 4'(i + 6));
      held = m_row();
      chk("bp_row_out", 32'(row_out), 32'(held));
      bus_valid = 1'b1;
      dest_sel  = 2'd0;
      bus_in    = 4'h9;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_row", 32'(row_out), 32'(held));
         chk("bp_hold_mask", 32'(slot_mask), 32'hF);
         chk("bp_hold_ready", 32'(bus_ready), 32'h0);
      end
      bus_valid = 1'b0;
      ack();
      chk_ctrl("bp_ack");
      chk("bp_ack_row", 32'(row_out), 32'(held));

      // last row of the frame: index wraps and frame_done pulses once
      fd_base = fd_count;
      for (int i = 3; i >= 0; i--) write(2'(i), 4'(i + 1));
      chk("wrap_idx3", 32'(row_idx), 32'h3);
      ack();
      chk_ctrl("wrap_ack");
      chk("wrap_fd_pulse", 32'(frame_done), 32'h1);
      @(posedge clk);
      #1;
      m_fd = 1'b0;
      chk("wrap_fd_clear", 32'(frame_done), 32'h0);
      chk("wrap_fd_count", 32'(fd_count - fd_base), 32'h1);

      // reset in the middle of a row
      write(2'd0, 4'hE);
      write(2'd3, 4'hE);
      do_reset(1);
      chk_ctrl("midrow_reset");
      for (int i = 0; i < 4; i++) write(2'(i), 4'(i + 1));
      chk("midrow_row_out", 32'(row_out), 32'h4321);
      chk("midrow_idx", 32'(row_idx), 32'h0);

      // reset and acknowledge together while a row is presented
      fd_base = fd_count;
      rst     = 1'b1;
      row_ack = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      row_ack = 1'b0;
      m_reset();
      chk_ctrl("rst_ack");
      chk("rst_ack_row_out", 32'(row_out), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_ack_no_fd", 32'(fd_count - fd_base), 32'h0);

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/databus_row_capture.md
DATABUS_ROW_CAPTURE -- requirements
Module: databus_row_capture

Interface
REQ-001 SHALL have parameter DW, default 4, meaning pixel width on the databus in bits.
REQ-002 SHALL have parameter NROWS, default 4, meaning rows per frame; legal range 2..4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bus_in, input, DW, pixel word driven from the shared 4-bit databus.
REQ-006 SHALL have port bus_valid, input, 1, meaning bus_in and dest_sel are valid this cycle.
REQ-007 SHALL have port dest_sel, input, 2, destination column slot 0..3 for bus_in.
REQ-008 SHALL have port bus_ready, output, 1, meaning the block accepts a word this cycle.
REQ-009 SHALL have port row_out, output, 4*DW, assembled row; slot k at bits [k*DW +: DW].
REQ-010 SHALL have port row_valid, output, 1, meaning row_out holds a complete row.
REQ-011 SHALL have port row_ack, input, 1, consumer acknowledgement of the presented row.
REQ-012 SHALL have port row_idx, output, 2, index of the row being filled or presented, 0..NROWS-1.
REQ-013 SHALL have port slot_mask, output, 4, bit k set when slot k has been written in the current row.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the last row of a frame is acknowledged.

Function
REQ-015 SHALL implement two states: FILL (bus_ready=1, row_valid=0) and FULL (bus_ready=0, row_valid=1).
REQ-016 SHALL accept a word only when bus_valid=1 and bus_ready=1, writing bus_in into slot dest_sel and setting slot_mask[dest_sel] on the same edge.
REQ-017 SHALL overwrite a slot rewritten before the row completes; last write wins, slot_mask unchanged for that bit.
REQ-018 SHALL transition FILL->FULL on the edge where the accepted write makes slot_mask 4'b1111; row_valid is asserted the following cycle (1-cycle latency from the 4th distinct write).
REQ-019 SHALL hold row_out, row_idx and row_valid stable in FULL until row_ack=1 is sampled.
REQ-020 SHALL ignore bus_valid in FULL; no slot or mask changes.
REQ-021 SHALL on row_ack=1 in FULL: clear slot_mask, return to FILL, and increment row_idx, wrapping NROWS-1 -> 0; bus_ready is 1 in the next cycle.
REQ-022 SHALL pulse frame_done for exactly the cycle after the acknowledge edge on which row_idx wraps to 0.
REQ-023 SHALL ignore row_ack in FILL.
REQ-024 SHALL leave row_out slot contents unchanged on acknowledge; slots are overwritten only by new writes.
REQ-025 SHALL drive all outputs from registers or from state only (no combinational path from bus_valid or row_ack to any output).

Reset
REQ-026 SHALL on rst=1 at a clock edge set state FILL, row_out=0, slot_mask=4'b0000, row_idx=0, row_valid=0, frame_done=0; bus_ready=1 from the first cycle after reset deasserts.
REQ-027 SHALL give rst priority over any simultaneous bus_valid or row_ack, discarding partial rows and presented rows.

Verification
REQ-028 SHALL verify fill in order: writes 0xA,0xB,0xC,0xD to slots 0..3 -> row_valid=1 one cycle later, row_out=16'hDCBA, bus_ready=0, row_idx=0.
REQ-029 SHALL verify out-of-order fill with overwrite: slot2=0x1, slot2=0x7, slot0=0x3, slot3=0xF, slot1=0x5 -> row_out=16'hF753; row_valid does not assert before the 5th write.
REQ-030 SHALL verify backpressure: in FULL, drive bus_valid=1 with slot0=0x9 for 3 cycles, then row_ack -> row_out unchanged, slot_mask=0, bus_ready=1 next cycle.
REQ-031 SHALL verify frame wrap: 4 complete rows each acknowledged -> row_idx sequence 0,1,2,3,0 and a single frame_done pulse after the 4th ack.
REQ-032 SHALL verify reset mid-row: 2 writes, rst for 1 cycle, then 4 writes of 0x1..0x4 to slots 0..3 -> slot_mask clears on reset, row_out=16'h4321, row_idx=0.
REQ-033 SHALL verify simultaneous rst and row_ack in FULL -> reset values, frame_done=0, row_idx=0.
